// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front-end with credit-limited response FIFO and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_inst
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          id_valid_q, id_valid_d;
    logic [31:0]   id_pc_q, id_pc_d, id_inst_q, id_inst_d;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_inst [FIFO_DEPTH];

    logic [CW:0]   credit_sum;
    logic [CW-1:0] out_dec;
    logic          accept, push, pop, load;

    // Credits cover both in-flight requests and buffered words, so the FIFO can never overflow.
    assign credit_sum     = {1'b0, out_q} + {1'b0, cnt_q};
    assign imem_req_valid = !reset && !redirect_valid && (credit_sum < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign out_dec        = out_q + CW'(accept) - CW'(imem_rsp_valid);
    assign push           = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    assign load           = !id_valid_q || id_ready;
    assign pop            = load && (cnt_q != '0) && !redirect_valid;

    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_q + 32'd4;
    assign id_inst     = id_inst_q;

    always_comb begin
        pc_d       = accept ? pc_q + 32'd4 : pc_q;
        rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        out_d      = out_dec;
        drop_d     = (imem_rsp_valid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        wr_d       = push ? wr_q + AW'(1) : wr_q;
        rd_d       = pop ? rd_q + AW'(1) : rd_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        if (load) begin
            if (cnt_q != '0) begin
                id_valid_d = 1'b1;
                id_pc_d    = fifo_pc[rd_q];
                id_inst_d  = fifo_inst[rd_q];
            end else begin
                id_valid_d = 1'b0;
                id_inst_d  = NOP_INST;
            end
        end
        // Redirect wins: everything still in flight becomes stale and is counted into drop_cnt.
        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            drop_d     = out_dec;
            cnt_d      = '0;
            wr_d       = '0;
            rd_d       = '0;
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0;
            id_inst_q  <= NOP_INST;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_q]   <= rsp_pc_q;
            fifo_inst[wr_q] <= imem_rsp_data;
        end
        if (!reset) begin
            assert (!(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
        end
    end
endmodule
